// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types and constants for the tic-tac-toe board slice.
// Cell masks are row-major, bit0=a .. bit8=i.
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    OVER
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int CELL_A = 0;
  localparam int CELL_B = 1;
  localparam int CELL_C = 2;
  localparam int CELL_D = 3;
  localparam int CELL_E = 4;
  localparam int CELL_F = 5;
  localparam int CELL_G = 6;
  localparam int CELL_H = 7;
  localparam int CELL_I = 8;

  // Entry order: rows 0-2, columns 3-5, main diag 6, anti-diag 7
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h054, 9'h111,
    9'h124, 9'h092, 9'h049,
    9'h1C0, 9'h038, 9'h007
  };

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v,
    input logic       en
  );
    return (en && v != 4'hF) ? v + 4'd1 : v;
  endfunction

endpackage

// File: rtl/ttt_board_ctrl_if.sv
// ttt_board_ctrl_if: button inputs and board/status outputs.
// TTT_SCORE_EN adds the score counter signals.
interface ttt_board_ctrl_if;
  logic       game_mode;
  logic       new_game;
  logic [8:0] btn;
  logic [8:0] occupied;
  logic [8:0] owner;
  logic       p1_turn;
  logic       move_accept;
  logic       move_reject;
  logic       game_over;
  logic [1:0] winner;
  logic [7:0] win_line;
`ifdef TTT_SCORE_EN
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [3:0] score_draw;

  modport master (
    output game_mode, new_game, btn,
    input  occupied, owner, p1_turn,
    input  move_accept, move_reject,
    input  game_over, winner, win_line,
    input  score_p1, score_p2, score_draw
  );
  modport slave (
    input  game_mode, new_game, btn,
    output occupied, owner, p1_turn,
    output move_accept, move_reject,
    output game_over, winner, win_line,
    output score_p1, score_p2, score_draw
  );
`else
  modport master (
    output game_mode, new_game, btn,
    input  occupied, owner, p1_turn,
    input  move_accept, move_reject,
    input  game_over, winner, win_line
  );
  modport slave (
    input  game_mode, new_game, btn,
    output occupied, owner, p1_turn,
    output move_accept, move_reject,
    output game_over, winner, win_line
  );
`endif
endinterface

// File: rtl/ttt_win_check.sv
// ttt_win_check: combinational line/full evaluation for one mover.
// Also intended for the AI stage to score candidate boards.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [8:0] occupied,
  input  logic [8:0] owner,
  input  logic       mover,
  output logic [7:0] line_hit,
  output logic       full
);

  logic [8:0] mine;

  always_comb begin
    mine     = occupied & ~(owner ^ {9{mover}});
    line_hit = '0;
    for (int i = 0; i < 8; i++) begin
      line_hit[i] = (mine & WIN_LINES[i]) == WIN_LINES[i];
    end
    full = &occupied;
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl: move validation, board storage, win/draw and turn handover.
// Define TTT_SCORE_EN to add saturating win/draw score counters.
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit P2_FIRST    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  ttt_board_ctrl_if.slave bus
);

  logic [SYNC_STAGES-1:0][8:0] sync_q, sync_d;
  logic [8:0] prev_q, prev_d;
  logic [8:0] req_q, req_d;
  state_e     state_q, state_d;
  logic [8:0] occ_q, occ_d;
  logic [8:0] own_q, own_d;
  logic       p1_turn_q, p1_turn_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] win_line_q, win_line_d;
  logic       accept, reject;
  logic       req_any, req_multi, req_clash;
  logic [7:0] line_hit;
  logic       full;
  wire        unused_game_mode = bus.game_mode;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.btn};
    prev_d = sync_q[SYNC_STAGES-1];
    req_d  = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  assign req_any   = |req_q;
  assign req_multi = (req_q & (req_q - 9'd1)) != 9'd0;
  assign req_clash = |(req_q & occ_q);

  ttt_win_check u_win (
    .occupied (occ_q),
    .owner    (own_q),
    .mover    (p1_turn_q),
    .line_hit (line_hit),
    .full     (full)
  );

  // Edge history survives new_game so a held button never re-fires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      req_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      req_q  <= req_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PLAY;
      occ_q      <= '0;
      own_q      <= '0;
      p1_turn_q  <= P2_FIRST;
      winner_q   <= WIN_NONE;
      win_line_q <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      own_q      <= own_d;
      p1_turn_q  <= p1_turn_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    own_d      = own_q;
    p1_turn_d  = p1_turn_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    if (bus.new_game) begin
      state_d    = PLAY;
      occ_d      = '0;
      own_d      = '0;
      p1_turn_d  = P2_FIRST;
      winner_d   = WIN_NONE;
      win_line_d = '0;
    end else begin
      unique case (1'b1)
        state_q == PLAY: begin
          if (accept) begin
            occ_d   = occ_q | req_q;
            own_d   = (own_q & ~req_q) | (req_q & {9{p1_turn_q}});
            state_d = CHECK;
          end
        end
        state_q == CHECK: begin
          if (|line_hit) begin
            winner_d   = p1_turn_q ? WIN_P2 : WIN_P1;
            win_line_d = line_hit;
            state_d    = OVER;
          end else if (full) begin
            winner_d = WIN_DRAW;
            state_d  = OVER;
          end else begin
            p1_turn_d = ~p1_turn_q;
            state_d   = PLAY;
          end
        end
        state_q == OVER: state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
  end

  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    if (!bus.new_game && req_any) begin
      unique case (1'b1)
        state_q == PLAY: begin
          accept = !req_multi && !req_clash;
          reject = req_multi || req_clash;
        end
        state_q == OVER: reject = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.occupied    = occ_q;
  assign bus.owner       = own_q;
  assign bus.p1_turn     = p1_turn_q;
  assign bus.move_accept = accept;
  assign bus.move_reject = reject;
  assign bus.game_over   = state_q == OVER;
  assign bus.winner      = winner_q;
  assign bus.win_line    = win_line_q;

`ifdef TTT_SCORE_EN
  logic [3:0] sc_p1_q, sc_p2_q, sc_dr_q;
  logic [3:0] sc_p1_d, sc_p2_d, sc_dr_d;
  logic       enter_over;

  assign enter_over = (state_q != OVER) && (state_d == OVER);

  always_comb begin
    sc_p1_d = sat_inc(sc_p1_q, enter_over && winner_d == WIN_P1);
    sc_p2_d = sat_inc(sc_p2_q, enter_over && winner_d == WIN_P2);
    sc_dr_d = sat_inc(sc_dr_q, enter_over && winner_d == WIN_DRAW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_p1_q <= '0;
      sc_p2_q <= '0;
      sc_dr_q <= '0;
    end else begin
      sc_p1_q <= sc_p1_d;
      sc_p2_q <= sc_p2_d;
      sc_dr_q <= sc_dr_d;
    end
  end

  assign bus.score_p1   = sc_p1_q;
  assign bus.score_p2   = sc_p2_q;
  assign bus.score_draw = sc_dr_q;
`endif

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb_ttt_board_ctrl: directed vectors for two boards, P2_FIRST=0 and 1.
// Both boards see identical stimulus; expectations are hand-computed.
module tb_ttt_board_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ttt_board_ctrl_if ia ();
  ttt_board_ctrl_if ib ();

  ttt_board_ctrl #(
    .SYNC_STAGES (2),
    .P2_FIRST    (1'b0)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  ttt_board_ctrl #(
    .SYNC_STAGES (2),
    .P2_FIRST    (1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input logic [8:0] v);
    ia.btn = v;
    ib.btn = v;
  endtask

  task automatic set_ng(input logic v);
    ia.new_game = v;
    ib.new_game = v;
  endtask

  task automatic press(input logic [8:0] v);
    set_btn(v);
    tick(1);
    set_btn(9'd0);
  endtask

  task automatic do_move(input int k);
    logic [8:0] m;
    m = 9'd1 << k;
    press(m);
    tick(5);
  endtask

  task automatic ng_pulse();
    set_ng(1'b1);
    tick(1);
    set_ng(1'b0);
    tick(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_btn(9'd0);
    set_ng(1'b0);
    ia.game_mode = 1'b0;
    ib.game_mode = 1'b1;
    tick(2);

    chk("rst_occ", ia.occupied, 9'h000);
    chk("rst_own", ia.owner, 9'h000);
    chk("rst_turn_a", ia.p1_turn, 1'b0);
    chk("rst_turn_b", ib.p1_turn, 1'b1);
    chk("rst_acc", ia.move_accept, 1'b0);
    chk("rst_rej", ia.move_reject, 1'b0);
    chk("rst_over", ia.game_over, 1'b0);
    chk("rst_win", ia.winner, 2'b00);
    chk("rst_line", ia.win_line, 8'h00);
    reset = 1'b0;
    tick(2);

    // First move: accept at edge 3, p1_turn toggles at edge 5
    press(9'h010);
    tick(1);
    chk("t1_acc_early", ia.move_accept, 1'b0);
    tick(1);
    chk("t1_acc", ia.move_accept, 1'b1);
    chk("t1_turn_hold", ia.p1_turn, 1'b0);
    tick(1);
    chk("t1_acc_pulse", ia.move_accept, 1'b0);
    chk("t1_occ", ia.occupied, 9'h010);
    chk("t1_own4", ia.owner[4], 1'b0);
    chk("t1_own4_b", ib.owner[4], 1'b1);
    chk("t1_turn_chk", ia.p1_turn, 1'b0);
    tick(1);
    chk("t1_turn", ia.p1_turn, 1'b1);
    tick(2);

    // Re-press an occupied cell, then a double press
    press(9'h010);
    tick(2);
    chk("t3_rej_occ", ia.move_reject, 1'b1);
    chk("t3_acc_occ", ia.move_accept, 1'b0);
    tick(1);
    chk("t3_rej_pulse", ia.move_reject, 1'b0);
    tick(2);
    press(9'h003);
    tick(2);
    chk("t3_rej_dbl", ia.move_reject, 1'b1);
    chk("t3_acc_dbl", ia.move_accept, 1'b0);
    tick(3);
    chk("t3_occ", ia.occupied, 9'h010);
    chk("t3_turn", ia.p1_turn, 1'b1);

    // new_game in the cycle the btn[2] request is registered
    press(9'h004);
    tick(2);
    set_ng(1'b1);
    #1;
    chk("t5_acc_a", ia.move_accept, 1'b0);
    chk("t5_rej_a", ia.move_reject, 1'b0);
    chk("t5_acc_b", ib.move_accept, 1'b0);
    tick(1);
    set_ng(1'b0);
    chk("t5_occ_a", ia.occupied, 9'h000);
    chk("t5_turn_a", ia.p1_turn, 1'b0);
    chk("t5_occ_b", ib.occupied, 9'h000);
    chk("t5_turn_b", ib.p1_turn, 1'b1);
    tick(3);
    chk("t5_occ_late", ia.occupied, 9'h000);

    // Row a,b,c for the first mover; d,e for the second
    do_move(0);
    do_move(3);
    do_move(1);
    do_move(4);
    do_move(2);
    chk("t2_win_a", ia.winner, 2'b01);
    chk("t2_win_b", ib.winner, 2'b10);
    chk("t2_line", ia.win_line, 8'h01);
    chk("t2_over", ia.game_over, 1'b1);
    chk("t2_turn", ia.p1_turn, 1'b0);
    chk("t2_occ", ia.occupied, 9'h01F);
    chk("t2_own", ia.owner, 9'h018);
    press(9'h100);
    tick(2);
    chk("t2_rej_over", ia.move_reject, 1'b1);
    tick(3);
    chk("t2_occ_over", ia.occupied, 9'h01F);

    ng_pulse();
    chk("ng_win", ia.winner, 2'b00);
    chk("ng_line", ia.win_line, 8'h00);
    chk("ng_over", ia.game_over, 1'b0);

    // Draw: X a,c,d,h,i / O b,e,f,g
    do_move(0);
    do_move(1);
    do_move(2);
    do_move(4);
    do_move(3);
    do_move(5);
    do_move(7);
    do_move(6);
    chk("t4_no_over", ia.game_over, 1'b0);
    do_move(8);
    chk("t4_win", ia.winner, 2'b11);
    chk("t4_line", ia.win_line, 8'h00);
    chk("t4_over", ia.game_over, 1'b1);
    chk("t4_occ", ia.occupied, 9'h1FF);
    chk("t4_own", ia.owner, 9'h072);

    // Async reset while in CHECK
    ng_pulse();
    press(9'h001);
    tick(2);
    chk("t6_acc", ia.move_accept, 1'b1);
    tick(1);
    chk("t6_occ_pre", ia.occupied, 9'h001);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_occ", ia.occupied, 9'h000);
    chk("t6_own_b", ib.owner, 9'h000);
    chk("t6_turn_a", ia.p1_turn, 1'b0);
    chk("t6_turn_b", ib.p1_turn, 1'b1);
    chk("t6_win", ia.winner, 2'b00);
    chk("t6_over", ia.game_over, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(2);

`ifdef TTT_SCORE_EN
    for (int g = 0; g < 16; g++) begin
      ng_pulse();
      do_move(0);
      do_move(3);
      do_move(1);
      do_move(4);
      do_move(2);
    end
    chk("sc_p1", ia.score_p1, 4'd15);
    chk("sc_p2_b", ib.score_p2, 4'd15);
    chk("sc_draw", ia.score_draw, 4'd0);
    ng_pulse();
    chk("sc_keep", ia.score_p1, 4'd15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
